// File: rtl/bench_serial_harness.sv
// Serial test harness: deserializes MSB-first frames into dut_in, queues dut_out results
// and re-serializes them LSB-first. Latency: dut_start SYNC_STAGES edges after the last
// data bit; ser_out start bit 2 cycles after dut_valid. Backpressure: none, full FIFO drops and sets overflow.
module bench_serial_harness #(
    parameter int IN_BITS     = 16,
    parameter int OUT_BITS    = 5,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ser_in,
    output logic                ser_out,
    output logic [IN_BITS-1:0]  dut_in,
    output logic                dut_start,
    input  logic [OUT_BITS-1:0] dut_out,
    input  logic                dut_valid,
    output logic                overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int RCW = $clog2(IN_BITS + 1);
    localparam int TCW = $clog2(OUT_BITS + 2);
    localparam logic [RCW-1:0] RX_LAST  = RCW'(IN_BITS - 1);
    localparam logic [RCW-1:0] RX_ONE   = RCW'(1);
    localparam logic [TCW-1:0] TX_STOP  = TCW'(OUT_BITS + 1);
    localparam logic [TCW-1:0] TX_NDATA = TCW'(OUT_BITS);
    localparam logic [TCW-1:0] TX_ONE   = TCW'(1);
    localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);

    typedef enum logic {RX_IDLE, RX_DATA} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_rx_state, w_rx_next;
    logic [RCW-1:0]         r_rx_cnt;
    logic [IN_BITS-1:0]     r_rx_shift;
    tx_state_t              r_tx_state, w_tx_next;
    logic [TCW-1:0]         r_tx_cnt;
    logic [OUT_BITS-1:0]    r_tx_word;
    logic [OUT_BITS-1:0]    r_mem [DEPTH];
    logic [AW:0]            r_wr_ptr, r_rd_ptr;

    logic                   w_s_in;
    logic                   w_rx_done;
    logic [IN_BITS-1:0]     w_rx_word;
    logic                   w_empty, w_full, w_push, w_pop, w_tx_last;
    logic [OUT_BITS-1:0]    w_head;

    // Input synchronizer chain; stage 0 samples the raw line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= ser_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s_in    = r_sync[SYNC_STAGES-1];
    assign w_rx_word = (r_rx_shift << 1) | IN_BITS'(w_s_in);

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) r_rx_state <= RX_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    // Receiver next state: a 1 in idle is a start bit; the last data bit completes the word.
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            RX_IDLE: if (w_s_in) w_rx_next = RX_DATA;
            RX_DATA: if (r_rx_cnt == RX_LAST) begin
                w_rx_done = 1'b1;
                w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Receiver shift register, bit counter and output word/strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            dut_in     <= '0;
            dut_start  <= 1'b0;
        end else begin
            dut_start <= w_rx_done;
            if (r_rx_state == RX_IDLE) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_shift <= w_rx_word;
                r_rx_cnt   <= r_rx_cnt + RX_ONE;
            end
            if (w_rx_done) dut_in <= w_rx_word;
        end
    end

    // Full is judged on registered pointers, so a same-cycle pop never makes room for a push.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = dut_valid && !w_full;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    // FIFO storage; no reset needed since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr[AW-1:0]] <= dut_out;
    end

    // FIFO pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push)              r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)               r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (dut_valid && w_full) overflow <= 1'b1;
        end
    end

    assign w_tx_last = (r_tx_cnt == TX_STOP);

    // Transmitter state register.
    always_ff @(posedge clk) begin
        if (reset) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    // Transmitter next state: pop from idle, or straight after the stop bit for contiguous frames.
    always_comb begin
        w_tx_next = r_tx_state;
        w_pop     = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_empty) begin
                w_pop     = 1'b1;
                w_tx_next = TX_SEND;
            end
            TX_SEND: if (w_tx_last) begin
                if (!w_empty) w_pop = 1'b1;
                else          w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // Transmit shifter: r_tx_cnt indexes the bit currently on ser_out (0 start, OUT_BITS+1 stop).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_cnt  <= '0;
            r_tx_word <= '0;
            ser_out   <= 1'b0;
        end else if (w_pop) begin
            r_tx_word <= w_head;
            r_tx_cnt  <= '0;
            ser_out   <= 1'b1;
        end else if (r_tx_state == TX_SEND && !w_tx_last) begin
            r_tx_cnt <= r_tx_cnt + TX_ONE;
            if (r_tx_cnt < TX_NDATA) begin
                ser_out   <= r_tx_word[0];
                r_tx_word <= r_tx_word >> 1;
            end else begin
                ser_out <= 1'b0;
            end
        end else begin
            r_tx_cnt <= '0;
            ser_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bench_serial_harness.sv
// Directed bench for bench_serial_harness with scoreboards on both serial paths.
// Received words and transmitted frames are checked against queues filled at stimulus time.
// Inputs change 1ns after the rising edge; monitors sample on the falling edge.
module tb_bench_serial_harness;

    localparam int IB = 8;
    localparam int OB = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ser_in = 1'b0;
    logic          ser_out;
    logic [IB-1:0] dut_in;
    logic          dut_start;
    logic [OB-1:0] dut_out = '0;
    logic          dut_valid = 1'b0;
    logic          overflow;

    bench_serial_harness #(
        .IN_BITS(IB), .OUT_BITS(OB), .DEPTH(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_out(ser_out),
        .dut_in(dut_in), .dut_start(dut_start), .dut_out(dut_out),
        .dut_valid(dut_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail   = 0;

    logic [IB-1:0] rx_exp[$];
    logic [OB-1:0] tx_exp[$];
    int            rx_starts[$];
    int            tx_starts[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receive-side scoreboard: every dut_start must match the next expected word.
    always @(negedge clk) begin
        if (!reset && dut_start === 1'b1) begin
            rx_starts.push_back(cyc);
            if (rx_exp.size() == 0) chk("rx_unexpected_start", 32'd1, 32'd0);
            else                    chk("rx_word", 32'(dut_in), 32'(rx_exp.pop_front()));
        end
    end

    // Transmit-side deserializer and scoreboard; a reset abandons any partial frame.
    logic          tx_busy = 1'b0;
    int            tx_idx  = 0;
    logic [OB-1:0] tx_word = '0;
    always @(negedge clk) begin
        if (reset) begin
            tx_busy = 1'b0;
        end else if (!tx_busy) begin
            if (ser_out === 1'b1) begin
                tx_busy = 1'b1;
                tx_idx  = 0;
                tx_word = '0;
                tx_starts.push_back(cyc);
            end
        end else if (tx_idx < OB) begin
            tx_word[tx_idx] = ser_out;
            tx_idx++;
        end else begin
            chk("tx_stop_bit", 32'(ser_out), 32'd0);
            if (tx_exp.size() == 0) chk("tx_unexpected_frame", 32'd1, 32'd0);
            else                    chk("tx_word", 32'(tx_word), 32'(tx_exp.pop_front()));
            tx_busy = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        step();
        ser_in = b;
    endtask

    task automatic send_frame(input logic [IB-1:0] w);
        send_bit(1'b1);
        for (int i = IB - 1; i >= 0; i--) send_bit(w[i]);
        rx_exp.push_back(w);
    endtask

    int vcyc;

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_dut_in", 32'(dut_in), 32'd0);
        chk("rst_dut_start", 32'(dut_start), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Single frame 0xA5: strobe exactly two edges after the last data bit
        send_frame(8'hA5);
        step(); ser_in = 1'b0;
        chk("a5_start_k", 32'(dut_start), 32'd0);
        step();
        chk("a5_start_k1", 32'(dut_start), 32'd0);
        step();
        chk("a5_start_k2", 32'(dut_start), 32'd1);
        chk("a5_word_k2", 32'(dut_in), 32'hA5);
        step();
        chk("a5_pulse_end", 32'(dut_start), 32'd0);
        repeat (5) step();
        chk("a5_hold", 32'(dut_in), 32'hA5);

        // Back-to-back frames
        rx_starts.delete();
        send_frame(8'h3C);
        send_frame(8'hC3);
        step(); ser_in = 1'b0;
        repeat (5) step();
        chk("b2b_count", 32'(rx_starts.size()), 32'd2);
        if (rx_starts.size() == 2) chk("b2b_gap", 32'(rx_starts[1] - rx_starts[0]), 32'd9);
        chk("b2b_last_word", 32'(dut_in), 32'hC3);

        // Single transmit frame
        tx_starts.delete();
        step();
        dut_out = 5'b10110; dut_valid = 1'b1; vcyc = cyc;
        tx_exp.push_back(5'b10110);
        step(); dut_valid = 1'b0;
        repeat (10) step();
        chk("tx1_frames", 32'(tx_starts.size()), 32'd1);
        if (tx_starts.size() == 1) chk("tx1_latency", 32'(tx_starts[0] - vcyc), 32'd2);
        chk("tx1_idle_low", 32'(ser_out), 32'd0);

        // Six consecutive pushes: word 6 dropped, five contiguous frames
        tx_starts.delete();
        chk("ovf_initial", 32'(overflow), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 6) chk("ovf_before_drop", 32'(overflow), 32'd0);
            dut_out = OB'(i); dut_valid = 1'b1;
            if (i <= 5) tx_exp.push_back(OB'(i));
        end
        step(); dut_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (45) step();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("burst_frames", 32'(tx_starts.size()), 32'd5);
        for (int i = 1; i < tx_starts.size(); i++)
            chk("burst_gap", 32'(tx_starts[i] - tx_starts[i-1]), 32'd7);

        // Reset in the middle of a receive frame and a transmit frame
        rx_starts.delete();
        step(); dut_out = 5'h1F; dut_valid = 1'b1;
        step(); dut_valid = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        step();
        reset = 1'b1; ser_in = 1'b1; dut_valid = 1'b1; dut_out = 5'h03;
        step();
        reset = 1'b0; ser_in = 1'b0; dut_valid = 1'b0;
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("mid_rst_ser_out", 32'(ser_out), 32'd0);
            chk("mid_rst_no_start", 32'(dut_start), 32'd0);
            step();
        end
        chk("mid_rst_rx_starts", 32'(rx_starts.size()), 32'd0);
        send_frame(8'h01);
        step(); ser_in = 1'b0;
        repeat (4) step();
        chk("post_rst_word", 32'(dut_in), 32'h01);

        // All expected traffic consumed
        chk("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
        chk("tx_queue_empty", 32'(tx_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
